// File: rtl/f3_pd_pkg.sv
// f3_pd_pkg: shared types and constants for the F3 predecode consumer.
//   Fetch/RAS geometry, brType encodings, prediction kinds,
//   RAS entry layout and the registered prediction record.
package f3_pd_pkg;

  localparam int FETCH_WIDTH = 16;   // predecode slots per block, 2 bytes each
  localparam int RAS_DEPTH   = 16;   // stack entries, power of 2
  localparam int VADDR_W     = 39;
  localparam int CTR_W       = 3;    // recursion counter per entry

  localparam int IDX_W = $clog2(FETCH_WIDTH);
  localparam int SP_W  = $clog2(RAS_DEPTH);

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_JAL  = 2'b10;
  localparam logic [1:0] BR_JALR = 2'b11;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_CALL = 2'd1;
  localparam logic [1:0] KIND_RET  = 2'd2;
  localparam logic [1:0] KIND_JUMP = 2'd3;

  typedef struct packed {
    logic [VADDR_W-1:0] addr;
    logic [CTR_W-1:0]   ctr;
  } ras_entry_t;

  typedef struct packed {
    logic               hit;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         kind;
    logic               tgtValid;
    logic [VADDR_W-1:0] target;
  } pred_rec_t;

endpackage

// File: rtl/f3_ras_stack.sv
// f3_ras_stack: circular return-address stack with per-entry recursion counters.
//   clock, reset    : clock, async active-low reset
//   doPush/pushAddr : push a return address (merges into top on repeat call)
//   doPop           : pop top; both together = pop then push on post-pop state
//   topValid/topAddr: combinational view of the current top (before this cycle's op)
module f3_ras_stack
  import f3_pd_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               doPush,
  input  logic               doPop,
  input  logic [VADDR_W-1:0] pushAddr,
  output logic               topValid,
  output logic [VADDR_W-1:0] topAddr
);

  localparam logic [CTR_W-1:0] CTR_MAX   = '1;
  localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);
  localparam logic [SP_W-1:0]  SP_ONE    = SP_W'(1);
  localparam logic [SP_W:0]    CNT_ONE   = (SP_W+1)'(1);
  localparam logic [SP_W:0]    DEPTH_CNT = (SP_W+1)'(RAS_DEPTH);

  ras_entry_t [RAS_DEPTH-1:0] entries, entriesNxt;
  logic [SP_W-1:0] sp, spNxt, midSp;
  logic [SP_W:0]   count, countNxt, midCount;
  ras_entry_t      top, midTop;

  // sp always points at the current top entry
  assign top      = entries[sp];
  assign topValid = (count != '0);
  assign topAddr  = top.addr;

  // Pop first into the mid* state, then apply the push to that state, so a
  // call+ret in the same slot behaves as a coroutine swap.
  always_comb begin
    entriesNxt = entries;
    midSp      = sp;
    midCount   = count;
    if (doPop && topValid) begin
      if (top.ctr != '0) entriesNxt[sp].ctr = top.ctr - CTR_ONE;
      else begin
        midSp    = sp - SP_ONE;
        midCount = count - CNT_ONE;
      end
    end
    midTop   = entriesNxt[midSp];
    spNxt    = midSp;
    countNxt = midCount;
    if (doPush) begin
      if (midCount != '0 && midTop.addr == pushAddr && midTop.ctr != CTR_MAX) begin
        entriesNxt[midSp].ctr = midTop.ctr + CTR_ONE;
      end else begin
        // when full, the increment lands on the oldest entry and replaces it
        spNxt             = midSp + SP_ONE;
        entriesNxt[spNxt] = '{addr: pushAddr, ctr: '0};
        countNxt          = (midCount == DEPTH_CNT) ? DEPTH_CNT : midCount + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entries <= '0;
      sp      <= '0;
      count   <= '0;
    end else begin
      entries <= entriesNxt;
      sp      <= spNxt;
      count   <= countNxt;
    end
  end

endmodule

// File: rtl/f3_ras_updater.sv
// f3_ras_updater: F3 predecode consumer. Picks the first jal/jalr in the valid
// slots of a fetch block, updates the RAS, and emits a registered prediction.
//   clock, reset           : clock, async active-low reset
//   io_in_*                : predecode bundle (valid/ready), pc, mask, per-slot pd
//   io_flush               : kills the pending record and blocks acceptance
//   io_out_*               : prediction record (valid/ready): hit, idx, kind,
//                            tgt_valid, target (popped return address)
module f3_ras_updater
  import f3_pd_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_in_valid,
  output logic                     io_in_ready,
  input  logic [VADDR_W-1:0]       io_in_pc,
  input  logic [FETCH_WIDTH-1:0]   io_in_mask,
  input  logic [2*FETCH_WIDTH-1:0] io_in_pd_brType,
  input  logic [FETCH_WIDTH-1:0]   io_in_pd_isCall,
  input  logic [FETCH_WIDTH-1:0]   io_in_pd_isRet,
  input  logic [FETCH_WIDTH-1:0]   io_in_pd_isRVC,
  input  logic                     io_flush,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic                     io_out_hit,
  output logic [IDX_W-1:0]         io_out_idx,
  output logic [1:0]               io_out_kind,
  output logic                     io_out_tgt_valid,
  output logic [VADDR_W-1:0]       io_out_target
);

  logic [FETCH_WIDTH-1:0]              isJump;
  logic [FETCH_WIDTH-1:0][VADDR_W-1:0] retAddr;
  logic                                hit;
  logic [IDX_W-1:0]                    sel;
  logic                                selCall, selRet;
  logic                                fire, doPush, doPop;
  logic                                topValid;
  logic [VADDR_W-1:0]                  topAddr;
  pred_rec_t                           rec, recNxt;
  logic                                outValid;

  // Per-slot jump detect and return address (adder wraps at VADDR_W).
  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : gSlot
    logic [1:0] bt;
    assign bt         = io_in_pd_brType[2*i +: 2];
    assign isJump[i]  = io_in_mask[i] & ((bt == BR_JAL) | (bt == BR_JALR));
    assign retAddr[i] = io_in_pc + VADDR_W'(2*i)
                      + (io_in_pd_isRVC[i] ? VADDR_W'(2) : VADDR_W'(4));
  end

  // Lowest set slot wins: scan high to low so the last write is the lowest.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = FETCH_WIDTH-1; i >= 0; i--) begin
      if (isJump[i]) begin
        hit = 1'b1;
        sel = IDX_W'(i);
      end
    end
  end

  assign selCall     = io_in_pd_isCall[sel];
  assign selRet      = io_in_pd_isRet[sel];
  assign io_in_ready = (!outValid | io_out_ready) & !io_flush;
  assign fire        = io_in_valid & io_in_ready;
  assign doPop       = fire & hit & selRet;
  assign doPush      = fire & hit & selCall;

  f3_ras_stack uStack (
    .clock    (clock),
    .reset    (reset),
    .doPush   (doPush),
    .doPop    (doPop),
    .pushAddr (retAddr[sel]),
    .topValid (topValid),
    .topAddr  (topAddr)
  );

  // Return takes precedence over call for the reported kind.
  always_comb begin
    recNxt = '0;
    if (hit) begin
      recNxt.hit = 1'b1;
      recNxt.idx = sel;
      if (selRet) begin
        recNxt.kind     = KIND_RET;
        recNxt.tgtValid = topValid;
        recNxt.target   = topValid ? topAddr : '0;
      end else if (selCall) begin
        recNxt.kind = KIND_CALL;
      end else begin
        recNxt.kind = KIND_JUMP;
      end
    end
  end

  // Record fields hold after valid drops; only a new fire replaces them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outValid <= 1'b0;
      rec      <= '0;
    end else if (fire) begin
      outValid <= 1'b1;
      rec      <= recNxt;
    end else if (io_out_ready || io_flush) begin
      outValid <= 1'b0;
    end
  end

  assign io_out_valid     = outValid;
  assign io_out_hit       = rec.hit;
  assign io_out_idx       = rec.idx;
  assign io_out_kind      = rec.kind;
  assign io_out_tgt_valid = rec.tgtValid;
  assign io_out_target    = rec.target;

endmodule
